core_seq: RTL

- Parametrised instruction sequencer that drives one attention core: the MAC array, output FIFO, Q/K/PSUM SRAMs and SFP row.
- Replaces the hand-driven instruction word with an autonomous sequence: K load, Q load, kernel preload, execute, drain, optional normalise.
- Generates the per-unit clock enables, gating each unit when it is not in use.
- Sits beside the core; its inst/clk_en outputs feed the core directly.

---
 rtl/core_seq_pkg.sv | 67 ++++++
 rtl/core_seq_if.sv | 28 ++
 rtl/core_seq_decode.sv | 107 ++++++++++
 rtl/core_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the attention-core sequencer: state encoding, instruction
// field positions, clock-enable indices and MAC mode opcodes (NACC/NDIV need CORE_SEQ_NORM_EN).
package core_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KLOAD,
      S_QLOAD,
      S_KPRE,
      S_EXEC,
      S_DRAIN
`ifdef CORE_SEQ_NORM_EN
      , S_NACC,
      S_NDIV
`endif
   } state_t;

   localparam int INST_PMEM_WR  = 0;
   localparam int INST_PMEM_RD  = 1;
   localparam int INST_KMEM_WR  = 2;
   localparam int INST_KMEM_RD  = 3;
   localparam int INST_QMEM_WR  = 4;
   localparam int INST_QMEM_RD  = 5;
   localparam int INST_MODE_LSB = 6;
   localparam int INST_PMEM_ADD = 8;

   // Fields above the two address buses move with the address width.
   function automatic int inst_qkmem_add(input int aw);
      return 8 + aw;
   endfunction

   function automatic int inst_ofifo_rd(input int aw);
      return 8 + 2 * aw;
   endfunction

   function automatic int inst_div(input int aw);
      return 9 + 2 * aw;
   endfunction

   function automatic int inst_acc(input int aw);
      return 10 + 2 * aw;
   endfunction

   function automatic int inst_fifo_ext_rd(input int aw);
      return 11 + 2 * aw;
   endfunction

   function automatic int inst_write_back(input int aw);
      return 12 + 2 * aw;
   endfunction

   function automatic int inst_width(input int aw);
      return 13 + 2 * aw;
   endfunction

   localparam logic [1:0] MODE_KLOAD = 2'b01;
   localparam logic [1:0] MODE_EXEC  = 2'b10;

   localparam int CE_ARRAY = 0;
   localparam int CE_OFIFO = 1;
   localparam int CE_QMEM  = 2;
   localparam int CE_KMEM  = 3;
   localparam int CE_PMEM  = 4;
   localparam int CE_SFP   = 5;
   localparam int CE_W     = 6;

endpackage

// File: rtl/core_seq_if.sv
// Handshake and control bundle between the sequencer (slave) and whatever drives
// start/load/fifo status (master); inst and clk_en feed the attention core.
interface core_seq_if
   import core_seq_pkg::*;
#(
   parameter int AW = 4,
   parameter int IW = 13 + 2 * AW
);
   logic            start;
   logic [AW:0]     n_q;
   logic            load_valid;
   logic            load_ready;
   logic            fifo_valid;
   logic [IW-1:0]   inst;
   logic [CE_W-1:0] clk_en;
   logic            busy;
   logic            done;

   modport master (
      output start, n_q, load_valid, fifo_valid,
      input  load_ready, inst, clk_en, busy, done
   );

   modport slave (
      input  start, n_q, load_valid, fifo_valid,
      output load_ready, inst, clk_en, busy, done
   );
endinterface

// File: rtl/core_seq_decode.sv
// Combinational decode of sequencer state/address into the core instruction word,
// per-unit clock enables and load_ready; CORE_SEQ_NORM_EN adds the NACC/NDIV decodes.
module core_seq_decode
   import core_seq_pkg::*;
#(
   parameter int AW        = 4,
   parameter int IW        = 13 + 2 * AW,
   parameter int GATE_IDLE = 1
) (
   input  state_t          state,
   input  logic [AW-1:0]   addr,
`ifdef CORE_SEQ_NORM_EN
   input  logic            div_wr_phase,
`endif
   input  logic            load_valid,
   input  logic            fifo_valid,
   output logic [IW-1:0]   inst,
   output logic [CE_W-1:0] clk_en,
   output logic            load_ready
);

   localparam int P_QK  = inst_qkmem_add(AW);
   localparam int P_OFR = inst_ofifo_rd(AW);
`ifdef CORE_SEQ_NORM_EN
   localparam int P_DIV = inst_div(AW);
   localparam int P_ACC = inst_acc(AW);
   localparam int P_WB  = inst_write_back(AW);
`endif

   logic [CE_W-1:0] unit_on;

   // Each state turns on only the strobes and units it actually uses; the
   // external-FIFO read bit is never driven by the sequencer.
   always_comb begin
      inst       = '0;
      unit_on    = '0;
      load_ready = 1'b0;
      case (state)
         S_KLOAD: begin
            load_ready         = 1'b1;
            inst[INST_KMEM_WR] = load_valid;
            inst[P_QK +: AW]   = addr;
            unit_on[CE_KMEM]   = 1'b1;
         end
         S_QLOAD: begin
            load_ready         = 1'b1;
            inst[INST_QMEM_WR] = load_valid;
            inst[P_QK +: AW]   = addr;
            unit_on[CE_QMEM]   = 1'b1;
         end
         S_KPRE: begin
            inst[INST_KMEM_RD]          = 1'b1;
            inst[INST_MODE_LSB +: 2]    = MODE_KLOAD;
            inst[P_QK +: AW]            = addr;
            unit_on[CE_ARRAY]           = 1'b1;
            unit_on[CE_KMEM]            = 1'b1;
         end
         S_EXEC: begin
            inst[INST_QMEM_RD]          = 1'b1;
            inst[INST_MODE_LSB +: 2]    = MODE_EXEC;
            inst[P_QK +: AW]            = addr;
            unit_on[CE_ARRAY]           = 1'b1;
            unit_on[CE_OFIFO]           = 1'b1;
            unit_on[CE_QMEM]            = 1'b1;
         end
         S_DRAIN: begin
            inst[P_OFR]                 = fifo_valid;
            inst[INST_PMEM_WR]          = fifo_valid;
            inst[INST_PMEM_ADD +: AW]   = addr;
            unit_on[CE_ARRAY]           = 1'b1;
            unit_on[CE_OFIFO]           = 1'b1;
            unit_on[CE_PMEM]            = 1'b1;
         end
`ifdef CORE_SEQ_NORM_EN
         S_NACC: begin
            inst[INST_PMEM_RD]          = 1'b1;
            inst[P_ACC]                 = 1'b1;
            inst[INST_PMEM_ADD +: AW]   = addr;
            unit_on[CE_PMEM]            = 1'b1;
            unit_on[CE_SFP]             = 1'b1;
         end
         S_NDIV: begin
            if (div_wr_phase) begin
               inst[INST_PMEM_WR]       = 1'b1;
               inst[P_WB]               = 1'b1;
            end else begin
               inst[INST_PMEM_RD]       = 1'b1;
               inst[P_DIV]              = 1'b1;
            end
            inst[INST_PMEM_ADD +: AW]   = addr;
            unit_on[CE_PMEM]            = 1'b1;
            unit_on[CE_SFP]             = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   generate
      if (GATE_IDLE != 0) begin : g_gate
         assign clk_en = unit_on;
      end else begin : g_free
         assign clk_en = '1;
      end
   endgenerate

endmodule

// File: rtl/core_seq.sv
// Autonomous instruction sequencer for one attention core: K load, Q load, kernel preload,
// execute, drain, and (with CORE_SEQ_NORM_EN defined) accumulate/divide normalisation.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int COL       = 8,
   parameter int PR        = 8,
   parameter int DEPTH     = 16,
   parameter int GATE_IDLE = 1
) (
   input  logic      clk,
   input  logic      reset,
   core_seq_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = inst_width(AW);
   localparam int CW = AW + 2;
   localparam logic [AW:0]   NQ_MAX   = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   generate
      if (COL < 1 || COL > DEPTH || PR < 1) begin : g_bad_cfg
         $error("core_seq: COL must lie in 1..DEPTH and PR must be positive");
      end
   endgenerate

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW:0]   nq_q, nq_d;
   logic          busy_q, done_q;
   logic [CW-1:0] nq_last;
   logic          start_ok;
   logic [AW-1:0] addr;

   assign nq_last  = {1'b0, nq_q} - ONE;
   assign start_ok = bus.start && (bus.n_q != '0) && (bus.n_q <= NQ_MAX);

`ifdef CORE_SEQ_NORM_EN
   logic [CW-1:0] ndiv_last;
   assign ndiv_last = {nq_q, 1'b0} - ONE;
   // NDIV spends two cycles per address, so the address is the counter halved.
   assign addr      = (state_q == S_NDIV) ? cnt_q[AW:1] : cnt_q[AW-1:0];
`else
   assign addr      = cnt_q[AW-1:0];
`endif

   // Next-state: each phase advances its counter per transfer and leaves on the
   // last one; the counter is cleared on any state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nq_d    = nq_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_KLOAD;
               nq_d    = bus.n_q;
            end
         end
         S_KLOAD: begin
            if (bus.load_valid) begin
               cnt_d = cnt_q + ONE;
               if (cnt_q == COL_LAST) state_d = S_QLOAD;
            end
         end
         S_QLOAD: begin
            if (bus.load_valid) begin
               cnt_d = cnt_q + ONE;
               if (cnt_q == nq_last) state_d = S_KPRE;
            end
         end
         S_KPRE: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == COL_LAST) state_d = S_EXEC;
         end
         S_EXEC: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == nq_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (bus.fifo_valid) begin
               cnt_d = cnt_q + ONE;
`ifdef CORE_SEQ_NORM_EN
               if (cnt_q == nq_last) state_d = S_NACC;
`else
               if (cnt_q == nq_last) state_d = S_IDLE;
`endif
            end
         end
`ifdef CORE_SEQ_NORM_EN
         S_NACC: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == nq_last) state_d = S_NDIV;
         end
         S_NDIV: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == ndiv_last) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // busy mirrors the state just entered; done marks the first IDLE cycle after a pass.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nq_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nq_q    <= nq_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
      end
   end

   core_seq_decode #(
      .AW        (AW),
      .IW        (IW),
      .GATE_IDLE (GATE_IDLE)
   ) u_decode (
      .state        (state_q),
      .addr         (addr),
`ifdef CORE_SEQ_NORM_EN
      .div_wr_phase (cnt_q[0]),
`endif
      .load_valid   (bus.load_valid),
      .fifo_valid   (bus.fifo_valid),
      .inst         (bus.inst),
      .clk_en       (bus.clk_en),
      .load_ready   (bus.load_ready)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
